// File: rtl/io_bus_arbiter_if.sv
// io_bus_arbiter_if
// Bundles the two master request/response channels, the shared peripheral
// bus and the arbiter status outputs into one interface.
//   slave  modport : the arbiter's view (takes requests and read data,
//                    drives acks, rdata, bus strobes/fields and status)
//   master modport : the environment's view (masters plus peripheral)
// Signals:
//   mN_req/we/addr/wdata/size : request pulse and its payload, per master
//   mN_ack/rdata              : completion pulse and read result, per master
//   io_address/write_value/data_size/write_en/read_en : shared bus outputs
//   io_read_value             : peripheral read data, one cycle after read_en
//   busy, drop_err            : arbiter status
interface io_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [2:0]        m0_size;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [2:0]        m1_size;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] io_address;
    logic [DATA_W-1:0] io_write_value;
    logic [2:0]        io_data_size;
    logic              io_write_en;
    logic              io_read_en;
    logic [DATA_W-1:0] io_read_value;

    logic              busy;
    logic [1:0]        drop_err;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_size,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_size,
        input  io_read_value,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output io_address, io_write_value, io_data_size, io_write_en, io_read_en,
        output busy, drop_err
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_size,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_size,
        output io_read_value,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  io_address, io_write_value, io_data_size, io_write_en, io_read_en,
        input  busy, drop_err
    );
endinterface

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter
// Two-master arbiter in front of a single peripheral bus. Each master may
// have one request queued; a second request while one is queued or in
// flight is dropped and flagged in drop_err (sticky). Ties are resolved
// round-robin. One transaction runs at a time through IDLE -> ISSUE ->
// (WAIT for reads) -> DONE.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : io_bus_arbiter_if.slave (master channels, peripheral bus, status)
module io_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    io_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Granted master; retained in IDLE so it also serves as last-grant.
    logic gnt_q;
    logic bus_we_q;

    logic [ADDR_W-1:0] io_address_q;
    logic [DATA_W-1:0] io_write_value_q;
    logic [2:0]        io_data_size_q;
    logic              io_write_en_q;
    logic              io_read_en_q;

    // Per-master views, indexed by master number
    logic [1:0]        req_v;
    logic [1:0]        we_v;
    logic [ADDR_W-1:0] addr_v  [2];
    logic [DATA_W-1:0] wdata_v [2];
    logic [2:0]        size_v  [2];

    logic [1:0]        pend_v;
    logic [1:0]        drop_v;
    logic [1:0]        ack_v;
    logic [1:0]        hold_we_v;
    logic [ADDR_W-1:0] hold_addr_v  [2];
    logic [DATA_W-1:0] hold_wdata_v [2];
    logic [2:0]        hold_size_v  [2];
    logic [DATA_W-1:0] rdata_v      [2];

    logic grant_fire;
    logic pick;
    logic enter_done;

    assign req_v      = {bus.m1_req, bus.m0_req};
    assign we_v       = {bus.m1_we, bus.m0_we};
    assign addr_v[0]  = bus.m0_addr;
    assign addr_v[1]  = bus.m1_addr;
    assign wdata_v[0] = bus.m0_wdata;
    assign wdata_v[1] = bus.m1_wdata;
    assign size_v[0]  = bus.m0_size;
    assign size_v[1]  = bus.m1_size;

    // Next-state and grant selection
    always_comb begin
        state_d    = state_q;
        grant_fire = 1'b0;
        enter_done = 1'b0;
        // Both pending: the one not granted last. Otherwise whichever is pending.
        if (&pend_v) begin
            pick = ~gnt_q;
        end else begin
            pick = pend_v[1];
        end
        case (state_q)
            IDLE: begin
                if (|pend_v) begin
                    grant_fire = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                enter_done = bus_we_q;
                state_d    = bus_we_q ? DONE : WAIT;
            end
            WAIT: begin
                enter_done = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and shared bus registers. Strobes are registered on the grant
    // edge so they are high exactly during the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            gnt_q            <= 1'b1;
            bus_we_q         <= 1'b0;
            io_address_q     <= '0;
            io_write_value_q <= '0;
            io_data_size_q   <= '0;
            io_write_en_q    <= 1'b0;
            io_read_en_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            io_write_en_q <= grant_fire & hold_we_v[pick];
            io_read_en_q  <= grant_fire & ~hold_we_v[pick];
            if (grant_fire) begin
                gnt_q            <= pick;
                bus_we_q         <= hold_we_v[pick];
                io_address_q     <= hold_addr_v[pick];
                io_write_value_q <= hold_wdata_v[pick];
                io_data_size_q   <= hold_size_v[pick];
            end
        end
    end

    // Per-master pending flag, holding register, drop flag, ack and rdata
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        logic              pend_q;
        logic              drop_q;
        logic              ack_q;
        logic              hold_we_q;
        logic [ADDR_W-1:0] hold_addr_q;
        logic [DATA_W-1:0] hold_wdata_q;
        logic [2:0]        hold_size_q;
        logic [DATA_W-1:0] rdata_q;
        logic              is_gnt;
        logic              drop_now;

        // "Granted" spans ISSUE through DONE; a req in any of those cycles
        // for the in-flight master is dropped.
        assign is_gnt   = (state_q != IDLE) && (gnt_q == 1'(gi));
        assign drop_now = req_v[gi] && (pend_q || is_gnt);

        always_ff @(posedge clk) begin
            if (rst) begin
                pend_q       <= 1'b0;
                drop_q       <= 1'b0;
                ack_q        <= 1'b0;
                hold_we_q    <= 1'b0;
                hold_addr_q  <= '0;
                hold_wdata_q <= '0;
                hold_size_q  <= '0;
                rdata_q      <= '0;
            end else begin
                if (drop_now) begin
                    drop_q <= 1'b1;
                end
                // A grant needs pend_q set, which turns any same-cycle req
                // into a drop, so load and clear never collide.
                if (req_v[gi] && !drop_now) begin
                    pend_q       <= 1'b1;
                    hold_we_q    <= we_v[gi];
                    hold_addr_q  <= addr_v[gi];
                    hold_wdata_q <= wdata_v[gi];
                    hold_size_q  <= size_v[gi];
                end else if (grant_fire && (pick == 1'(gi))) begin
                    pend_q <= 1'b0;
                end
                ack_q <= enter_done && (gnt_q == 1'(gi));
                if ((state_q == WAIT) && (gnt_q == 1'(gi))) begin
                    rdata_q <= bus.io_read_value;
                end
            end
        end

        assign pend_v[gi]       = pend_q;
        assign drop_v[gi]       = drop_q;
        assign ack_v[gi]        = ack_q;
        assign hold_we_v[gi]    = hold_we_q;
        assign hold_addr_v[gi]  = hold_addr_q;
        assign hold_wdata_v[gi] = hold_wdata_q;
        assign hold_size_v[gi]  = hold_size_q;
        assign rdata_v[gi]      = rdata_q;
    end

    assign bus.m0_ack         = ack_v[0];
    assign bus.m1_ack         = ack_v[1];
    assign bus.m0_rdata       = rdata_v[0];
    assign bus.m1_rdata       = rdata_v[1];
    assign bus.io_address     = io_address_q;
    assign bus.io_write_value = io_write_value_q;
    assign bus.io_data_size   = io_data_size_q;
    assign bus.io_write_en    = io_write_en_q;
    assign bus.io_read_en     = io_read_en_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.drop_err       = drop_v;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter
// Table of single-master transactions from idle, followed by hand-written
// sequences for ties, drops, mid-transaction reset and back-to-back writes.
// A negedge monitor logs every strobe and ack with its cycle number.
module tb_io_bus_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    io_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    io_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral: registers read data one cycle after io_read_en
    logic [31:0] periph_data = 32'h0;
    always @(posedge clk) begin
        if (rst) bus.io_read_value <= 32'h0;
        else if (bus.io_read_en) bus.io_read_value <= periph_data;
    end

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
    } strobe_t;

    typedef struct {
        int          cyc;
        int          m;
        logic [31:0] rdata;
        logic [31:0] addr;
    } ack_t;

    strobe_t strobes[$];
    ack_t    acks[$];

    always @(negedge clk) begin
        if (bus.io_write_en || bus.io_read_en)
            strobes.push_back('{cyc, bus.io_write_en, bus.io_address, bus.io_write_value, bus.io_data_size});
        if (bus.m0_ack) acks.push_back('{cyc, 0, bus.m0_rdata, bus.io_address});
        if (bus.m1_ack) acks.push_back('{cyc, 1, bus.m1_rdata, bus.io_address});
    end

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_all();
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0; bus.m0_size = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_size = 0;
    endtask

    task automatic drive(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] size);
        if (m == 0) begin
            bus.m0_req = 1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_size = size;
        end else begin
            bus.m1_req = 1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_size = size;
        end
    endtask

    // Request pulse for one cycle; returns one cycle later
    task automatic issue(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] size);
        drive(m, we, addr, wdata, size);
        step();
        release_all();
    endtask

    task automatic reset_dut();
        rst = 1;
        release_all();
        repeat (3) step();
        rst = 0;
        strobes.delete();
        acks.delete();
    endtask

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] rd;
        int          ack_off;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int k;
        int got;
        logic [31:0] rd_now;

        vecs[0] = '{0, 1'b1, 32'h0000_0004, 32'h0000_1234, 3'd2, 32'h0,         3, 32'h0};
        vecs[1] = '{1, 1'b0, 32'h0000_0001, 32'h0,         3'd2, 32'h0000_A5A5, 4, 32'h0000_A5A5};
        vecs[2] = '{0, 1'b0, 32'h0000_0010, 32'h0,         3'd2, 32'hDEAD_BEEF, 4, 32'hDEAD_BEEF};
        vecs[3] = '{0, 1'b1, 32'h0000_0020, 32'h0000_CAFE, 3'd1, 32'h0,         3, 32'hDEAD_BEEF};
        vecs[4] = '{1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 3'd2, 32'h0,         3, 32'h0000_A5A5};
        vecs[5] = '{1, 1'b0, 32'h0000_0008, 32'h0,         3'd0, 32'h0000_0000, 4, 32'h0};

        reset_dut();

        // Reset state
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_drop_err", bus.drop_err, 0);
        chk("rst_strobes", {bus.io_write_en, bus.io_read_en}, 0);
        chk("rst_acks", {bus.m0_ack, bus.m1_ack}, 0);
        chk("rst_io_address", bus.io_address, 0);
        chk("rst_io_write_value", bus.io_write_value, 0);
        chk("rst_io_data_size", bus.io_data_size, 0);
        chk("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 0);
        step();

        // Single transactions from idle
        for (int i = 0; i < 6; i++) begin
            strobes.delete();
            acks.delete();
            periph_data = vecs[i].rd;
            k = cyc;
            issue(vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size);
            repeat (6) step();
            chk($sformatf("v%0d_strobe_count", i), strobes.size(), 1);
            if (strobes.size() >= 1) begin
                chk($sformatf("v%0d_strobe_cyc", i), strobes[0].cyc, k + 2);
                chk($sformatf("v%0d_strobe_we", i), strobes[0].we, vecs[i].we);
                chk($sformatf("v%0d_io_address", i), strobes[0].addr, vecs[i].addr);
                chk($sformatf("v%0d_io_data_size", i), strobes[0].size, vecs[i].size);
                if (vecs[i].we)
                    chk($sformatf("v%0d_io_write_value", i), strobes[0].wdata, vecs[i].wdata);
            end
            chk($sformatf("v%0d_ack_count", i), acks.size(), 1);
            if (acks.size() >= 1) begin
                chk($sformatf("v%0d_ack_master", i), acks[0].m, vecs[i].m);
                chk($sformatf("v%0d_ack_cyc", i), acks[0].cyc, k + vecs[i].ack_off);
                chk($sformatf("v%0d_ack_rdata", i), acks[0].rdata, vecs[i].exp_rdata);
                chk($sformatf("v%0d_addr_held", i), acks[0].addr, vecs[i].addr);
            end
            rd_now = (vecs[i].m == 0) ? bus.m0_rdata : bus.m1_rdata;
            chk($sformatf("v%0d_rdata_held", i), rd_now, vecs[i].exp_rdata);
            chk($sformatf("v%0d_busy_after", i), bus.busy, 0);
        end

        // Tie from reset: m0 first, m1 strobe two cycles after m0 ack
        reset_dut();
        k = cyc;
        drive(0, 1'b1, 32'h100, 32'h11, 3'd2);
        drive(1, 1'b1, 32'h200, 32'h22, 3'd2);
        step();
        release_all();
        repeat (10) step();
        chk("tie1_strobe_count", strobes.size(), 2);
        chk("tie1_ack_count", acks.size(), 2);
        if (strobes.size() == 2 && acks.size() == 2) begin
            chk("tie1_first_addr", strobes[0].addr, 32'h100);
            chk("tie1_first_cyc", strobes[0].cyc, k + 2);
            chk("tie1_m0_ack_master", acks[0].m, 0);
            chk("tie1_m0_ack_cyc", acks[0].cyc, k + 3);
            chk("tie1_second_addr", strobes[1].addr, 32'h200);
            chk("tie1_second_cyc", strobes[1].cyc, k + 5);
            chk("tie1_m1_ack_cyc", acks[1].cyc, k + 6);
        end

        // m0 served alone, so the next tie goes to m1
        issue(0, 1'b1, 32'h300, 32'h33, 3'd2);
        repeat (6) step();
        strobes.delete();
        acks.delete();
        k = cyc;
        drive(0, 1'b1, 32'h400, 32'h44, 3'd2);
        drive(1, 1'b1, 32'h500, 32'h55, 3'd2);
        step();
        release_all();
        repeat (10) step();
        chk("tie2_strobe_count", strobes.size(), 2);
        if (strobes.size() == 2) begin
            chk("tie2_first_addr", strobes[0].addr, 32'h500);
            chk("tie2_first_cyc", strobes[0].cyc, k + 2);
            chk("tie2_second_addr", strobes[1].addr, 32'h400);
        end
        chk("tie_drop_err", bus.drop_err, 0);

        // Second m0 req while the first is still pending is dropped
        reset_dut();
        issue(0, 1'b1, 32'h40, 32'hAA, 3'd2);
        issue(0, 1'b1, 32'h44, 32'hBB, 3'd2);
        repeat (8) step();
        chk("drop_err", bus.drop_err, 2'b01);
        chk("drop_strobe_count", strobes.size(), 1);
        if (strobes.size() >= 1) chk("drop_addr", strobes[0].addr, 32'h40);
        chk("drop_ack_count", acks.size(), 1);

        // Reset during WAIT of an m1 read, with an m0 write queued behind it
        reset_dut();
        periph_data = 32'h77;
        issue(1, 1'b0, 32'h8, 32'h0, 3'd2);
        issue(0, 1'b1, 32'h60, 32'h1, 3'd2);
        step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("rstw_busy", bus.busy, 0);
        chk("rstw_strobes", {bus.io_write_en, bus.io_read_en}, 0);
        chk("rstw_acks", {bus.m0_ack, bus.m1_ack}, 0);
        step();
        strobes.delete();
        repeat (8) step();
        chk("rstw_no_later_strobe", strobes.size(), 0);
        chk("rstw_no_ack", acks.size(), 0);
        chk("rstw_m1_rdata", bus.m1_rdata, 0);
        chk("rstw_drop_err", bus.drop_err, 0);

        // Back-to-back m0 writes, each req issued the cycle after the ack
        reset_dut();
        for (int t = 0; t < 4; t++) begin
            issue(0, 1'b1, 32'h1000 + 32'(t * 4), 32'(t), 3'd2);
            got = 0;
            for (int w = 0; w < 10 && got == 0; w++) begin
                @(negedge clk);
                if (bus.m0_ack) got = 1;
            end
            chk($sformatf("b2b_ack_seen_%0d", t), got, 1);
            step();
        end
        repeat (4) step();
        chk("b2b_strobe_count", strobes.size(), 4);
        chk("b2b_ack_count", acks.size(), 4);
        for (int t = 1; t < 4; t++) begin
            if (t < strobes.size()) begin
                chk($sformatf("b2b_period_%0d", t), strobes[t].cyc - strobes[t-1].cyc, 4);
                chk($sformatf("b2b_addr_%0d", t), strobes[t].addr, 32'h1000 + 32'(t * 4));
            end
        end
        chk("b2b_drop_err", bus.drop_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
